// File: rtl/oam_dma_if.sv
// ---------------------------------------------------------------------------
// oam_dma_if
//
// Bundles every non-clock, non-reset signal of the OAM DMA engine.
//
//   CPU bus side (DMA engine responds):
//     ce        CPU-cycle enable, one clk wide, at most once per 2 clk
//     ea        CPU bus address
//     dout      CPU write data
//     wreq      CPU write strobe
//     halt      holds the CPU stalled while high
//     busy      transfer in progress
//   SRAM read side (DMA engine initiates):
//     dma_addr  read address {page, idx}
//     dma_rd    read request
//     din       read data, valid 1 clk after dma_addr
//   PPU register-write side (DMA engine initiates):
//     ppu_addr  PPU register address ($2004 during a write strobe, else 0)
//     ppu_wdata byte being written to OAM
//     ppu_wreq  one-clk write strobe
//
// Modports:
//   master  the DMA engine's own view
//   slave   the view of the surrounding system (CPU, SRAM, PPU)
// ---------------------------------------------------------------------------
interface oam_dma_if;
  logic        ce;
  logic [15:0] ea;
  logic [7:0]  dout;
  logic        wreq;
  logic [7:0]  din;

  logic        halt;
  logic        busy;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_wdata;
  logic        ppu_wreq;

  modport master (
    input  ce,
    input  ea,
    input  dout,
    input  wreq,
    input  din,
    output halt,
    output busy,
    output dma_addr,
    output dma_rd,
    output ppu_addr,
    output ppu_wdata,
    output ppu_wreq
  );

  modport slave (
    output ce,
    output ea,
    output dout,
    output wreq,
    output din,
    input  halt,
    input  busy,
    input  dma_addr,
    input  dma_rd,
    input  ppu_addr,
    input  ppu_wdata,
    input  ppu_wreq
  );
endinterface

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//
// OAM DMA engine for the NES core. A CPU write to DMA_PORT ($4014) latches a
// source page; the engine then stalls the CPU and copies the 256 bytes
// {page, 8'h00} .. {page, 8'hFF} from system SRAM into sprite memory by
// writing each byte to the PPU's OAM_PORT ($2004).
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-low; clears every register on a clk edge
//   bus    oam_dma_if.master (CPU bus, SRAM read path, PPU write port)
//
// Sequencing (all transitions except the trigger happen on ce):
//   IDLE  --trigger--> HALT --ce--> (ALIGN --ce-->) READ --ce--> WRITE
//   WRITE --ce--> READ for the next byte, or IDLE after idx 8'hFF.
// ALIGN is inserted when the CPU-cycle parity is odd at the end of HALT, so
// that reads always land on the same CPU-cycle phase (513 or 514 cycles).
//
// All outputs are registers updated in the single FSM block below.
// ---------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] DMA_PORT = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic      clk,
  input  logic      reset,
  oam_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state_reg;
  logic [7:0]  page_reg;
  logic [7:0]  idx_reg;
  logic [7:0]  data_reg;
  logic        parity_reg;

  logic        halt_reg;
  logic        busy_reg;
  logic [15:0] dma_addr_reg;
  logic        dma_rd_reg;
  logic [15:0] ppu_addr_reg;
  logic        ppu_wreq_reg;

  logic [7:0]  idx_next;
  logic        trigger;
  logic        last_byte;

  assign idx_next  = idx_reg + 8'd1;
  assign trigger   = bus.wreq && (bus.ea == DMA_PORT);
  // idx never carries into page: the byte at idx 8'hFF closes the transfer.
  assign last_byte = (idx_reg == 8'hFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      page_reg     <= 8'h00;
      idx_reg      <= 8'h00;
      data_reg     <= 8'h00;
      parity_reg   <= 1'b0;
      halt_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      dma_addr_reg <= 16'h0000;
      dma_rd_reg   <= 1'b0;
      ppu_addr_reg <= 16'h0000;
      ppu_wreq_reg <= 1'b0;
    end else begin
      // CPU-cycle phase tracker; runs in every state, IDLE included.
      if (bus.ce) begin
        parity_reg <= ~parity_reg;
      end

      // The PPU strobe and its address live for exactly one clk; they are
      // re-armed only on the READ -> WRITE edge below.
      ppu_wreq_reg <= 1'b0;
      ppu_addr_reg <= 16'h0000;

      case (state_reg)
        IDLE: begin
          // Taken on any clk, whether or not ce is high on the same edge.
          if (trigger) begin
            page_reg  <= bus.dout;
            idx_reg   <= 8'h00;
            state_reg <= HALT;
            halt_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end

        HALT: begin
          // parity_reg here is the value before this ce toggles it.
          if (bus.ce) begin
            if (parity_reg) begin
              state_reg <= ALIGN;
            end else begin
              state_reg    <= READ;
              dma_rd_reg   <= 1'b1;
              dma_addr_reg <= {page_reg, idx_reg};
            end
          end
        end

        ALIGN: begin
          if (bus.ce) begin
            state_reg    <= READ;
            dma_rd_reg   <= 1'b1;
            dma_addr_reg <= {page_reg, idx_reg};
          end
        end

        READ: begin
          // dma_addr was presented on entry to READ and ce is at least 2 clk
          // away, so the registered SRAM output is already valid here.
          if (bus.ce) begin
            data_reg     <= bus.din;
            state_reg    <= WRITE;
            dma_rd_reg   <= 1'b0;
            ppu_wreq_reg <= 1'b1;
            ppu_addr_reg <= OAM_PORT;
          end
        end

        WRITE: begin
          if (bus.ce) begin
            if (last_byte) begin
              state_reg <= IDLE;
              halt_reg  <= 1'b0;
              busy_reg  <= 1'b0;
            end else begin
              idx_reg      <= idx_next;
              state_reg    <= READ;
              dma_rd_reg   <= 1'b1;
              dma_addr_reg <= {page_reg, idx_next};
            end
          end
        end

        default: begin
          state_reg  <= IDLE;
          halt_reg   <= 1'b0;
          busy_reg   <= 1'b0;
          dma_rd_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.halt      = halt_reg;
  assign bus.busy      = busy_reg;
  assign bus.dma_addr  = dma_addr_reg;
  assign bus.dma_rd    = dma_rd_reg;
  assign bus.ppu_addr  = ppu_addr_reg;
  assign bus.ppu_wdata = data_reg;
  assign bus.ppu_wreq  = ppu_wreq_reg;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
//
// Drives oam_dma through its interface with a registered SRAM model and a
// free-running ce generator. Expected OAM bytes are queued when a transfer
// is triggered and popped as ppu_wreq strobes appear.
// ---------------------------------------------------------------------------
module tb_oam_dma;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  oam_dma_if bus ();

  oam_dma #(
    .DMA_PORT(16'h4014),
    .OAM_PORT(16'h2004)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // SRAM contents: page 02 holds i ^ 8'h5A; other pages are distinct.
  function automatic logic [7:0] sram_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
  endfunction

  always @(posedge clk) bus.din <= sram_byte(bus.dma_addr);

  // ce generator: one-clk pulse every ce_gap clks.
  int ce_gap = 2;
  int ce_cnt = 0;
  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce_cnt++;
      if (ce_cnt >= ce_gap) begin
        ce_cnt = 0;
        bus.ce = 1'b1;
      end else begin
        bus.ce = 1'b0;
      end
    end
  end

  // Bench's own CPU-cycle parity.
  logic parity_m = 1'b0;
  always @(posedge clk) begin
    if (!reset) parity_m <= 1'b0;
    else if (bus.ce) parity_m <= ~parity_m;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor.
  logic [7:0]  exp_q[$];
  logic [7:0]  cur_page     = 8'h00;
  logic [15:0] last_rd_addr = 16'h0000;
  int          halt_ce      = 0;
  int          ce_before_rd = 0;
  bit          seen_rd      = 1'b0;
  bit          prev_wreq    = 1'b0;

  always @(negedge clk) begin
    if (bus.dma_rd) begin
      seen_rd      = 1'b1;
      last_rd_addr = bus.dma_addr;
      check("dma_rd_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("dma_addr", 32'(bus.dma_addr), 32'({cur_page, 8'(256 - exp_q.size())}));
    end
    if (bus.halt && bus.ce) begin
      halt_ce++;
      if (!seen_rd) ce_before_rd++;
    end
    if (bus.ppu_wreq) begin
      check("ppu_wreq_width", 32'(prev_wreq), 32'd0);
      check("ppu_addr", 32'(bus.ppu_addr), 32'h2004);
      check("ppu_wreq_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("ppu_wdata", 32'(bus.ppu_wdata), 32'(exp_q.pop_front()));
    end else if (bus.ppu_addr != 16'h0000) begin
      check("ppu_addr_idle", 32'(bus.ppu_addr), 32'h0);
    end
    prev_wreq = bus.ppu_wreq;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_halt"},      32'(bus.halt),      32'h0);
    check({tag, "_busy"},      32'(bus.busy),      32'h0);
    check({tag, "_dma_rd"},    32'(bus.dma_rd),    32'h0);
    check({tag, "_ppu_wreq"},  32'(bus.ppu_wreq),  32'h0);
    check({tag, "_dma_addr"},  32'(bus.dma_addr),  32'h0);
    check({tag, "_ppu_addr"},  32'(bus.ppu_addr),  32'h0);
    check({tag, "_ppu_wdata"}, 32'(bus.ppu_wdata), 32'h0);
  endtask

  // Trigger a transfer on an edge where the HALT-ending ce will see the
  // requested parity.
  task automatic start_xfer(input logic [7:0] page, input bit want_odd);
    int guard = 0;
    tick();
    while (((parity_m ^ bus.ce) != want_odd) && guard < 16) begin
      tick();
      guard++;
    end
    cur_page     = page;
    halt_ce      = 0;
    ce_before_rd = 0;
    seen_rd      = 1'b0;
    last_rd_addr = 16'h0000;
    for (int i = 0; i < 256; i++) exp_q.push_back(sram_byte({page, 8'(i)}));
    check("halt_before_trigger", 32'(bus.halt), 32'h0);
    bus.ea   = 16'h4014;
    bus.dout = page;
    bus.wreq = 1'b1;
    tick();
    bus.wreq = 1'b0;
    bus.ea   = 16'h0000;
    bus.dout = 8'h00;
    check("halt_rise", 32'(bus.halt), 32'h1);
    check("busy_rise", 32'(bus.busy), 32'h1);
  endtask

  task automatic finish_xfer(input logic [7:0] page, input bit odd, input int exp_len, input bit retrig);
    int guard = 0;
    while (bus.halt && guard < 6000) begin
      tick();
      guard++;
      if (retrig && guard == 300) begin
        bus.ea   = 16'h4014;
        bus.dout = 8'h07;
        bus.wreq = 1'b1;
      end else if (retrig && guard == 301) begin
        bus.wreq = 1'b0;
        bus.ea   = 16'h0000;
        bus.dout = 8'h00;
      end
    end
    check("halt_fall", 32'(bus.halt), 32'h0);
    check("busy_fall", 32'(bus.busy), 32'h0);
    check("halt_ce_count", 32'(halt_ce), 32'(exp_len));
    check("ce_before_first_read", 32'(ce_before_rd), odd ? 32'd2 : 32'd1);
    check("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    check("last_read_addr", 32'(last_rd_addr), 32'({page, 8'hFF}));
    check("dma_rd_after_done", 32'(bus.dma_rd), 32'h0);
    exp_q.delete();
    repeat (8) tick();
    check("idle_after_done", 32'(bus.halt), 32'h0);
  endtask

  typedef struct {
    logic [15:0] ea;
    logic [7:0]  dout;
    logic        exp_halt;
  } wr_vec_t;

  typedef struct {
    logic [7:0] page;
    bit         odd;
    int         gap;
    int         exp_len;
    bit         retrig;
  } xfer_vec_t;

  wr_vec_t   wr_tab [5];
  xfer_vec_t xf_tab [6];

  initial begin
    wr_tab[0] = '{ea: 16'h4013, dout: 8'h02, exp_halt: 1'b0};
    wr_tab[1] = '{ea: 16'h4015, dout: 8'h02, exp_halt: 1'b0};
    wr_tab[2] = '{ea: 16'h2004, dout: 8'h02, exp_halt: 1'b0};
    wr_tab[3] = '{ea: 16'h0014, dout: 8'h40, exp_halt: 1'b0};
    wr_tab[4] = '{ea: 16'hC014, dout: 8'h41, exp_halt: 1'b0};

    xf_tab[0] = '{page: 8'h02, odd: 1'b0, gap: 2, exp_len: 513, retrig: 1'b0};
    xf_tab[1] = '{page: 8'h02, odd: 1'b1, gap: 2, exp_len: 514, retrig: 1'b0};
    xf_tab[2] = '{page: 8'h02, odd: 1'b0, gap: 3, exp_len: 513, retrig: 1'b1};
    xf_tab[3] = '{page: 8'hFF, odd: 1'b0, gap: 2, exp_len: 513, retrig: 1'b0};
    xf_tab[4] = '{page: 8'hFF, odd: 1'b1, gap: 3, exp_len: 514, retrig: 1'b0};
    xf_tab[5] = '{page: 8'h5C, odd: 1'b1, gap: 2, exp_len: 514, retrig: 1'b0};

    bus.ea   = 16'h0000;
    bus.dout = 8'h00;
    bus.wreq = 1'b0;

    // Reset values.
    reset = 1'b0;
    repeat (4) tick();
    check_all_zero("reset");

    // Reset wins over a trigger on the same edge.
    bus.ea   = 16'h4014;
    bus.dout = 8'h33;
    bus.wreq = 1'b1;
    tick();
    bus.wreq = 1'b0;
    bus.ea   = 16'h0000;
    bus.dout = 8'h00;
    check("reset_beats_trigger", 32'(bus.halt), 32'h0);
    reset = 1'b1;
    repeat (3) tick();
    check("no_trigger_after_release", 32'(bus.busy), 32'h0);

    // Writes to other addresses are ignored.
    for (int i = 0; i < 5; i++) begin
      bus.ea   = wr_tab[i].ea;
      bus.dout = wr_tab[i].dout;
      bus.wreq = 1'b1;
      tick();
      bus.wreq = 1'b0;
      bus.ea   = 16'h0000;
      bus.dout = 8'h00;
      check($sformatf("nontrig_halt_%04h", wr_tab[i].ea), 32'(bus.halt), 32'(wr_tab[i].exp_halt));
      check($sformatf("nontrig_busy_%04h", wr_tab[i].ea), 32'(bus.busy), 32'(wr_tab[i].exp_halt));
      repeat (4) tick();
      check($sformatf("nontrig_late_%04h", wr_tab[i].ea), 32'(bus.halt), 32'(wr_tab[i].exp_halt));
      check($sformatf("nontrig_rd_%04h", wr_tab[i].ea), 32'(bus.dma_rd), 32'h0);
    end

    // Full transfers.
    for (int i = 0; i < 6; i++) begin
      ce_gap = xf_tab[i].gap;
      repeat (4) tick();
      start_xfer(xf_tab[i].page, xf_tab[i].odd);
      finish_xfer(xf_tab[i].page, xf_tab[i].odd, xf_tab[i].exp_len, xf_tab[i].retrig);
    end

    // Reset in the middle of a transfer, around byte 100.
    ce_gap = 2;
    repeat (4) tick();
    start_xfer(8'h02, 1'b0);
    begin
      int guard = 0;
      while (exp_q.size() > 156 && guard < 3000) begin
        tick();
        guard++;
      end
    end
    check("reached_byte_100", 32'(exp_q.size()), 32'd156);
    tick();
    reset = 1'b0;
    tick();
    exp_q.delete();
    check_all_zero("midreset");
    reset = 1'b1;
    repeat (60) tick();
    check("midreset_stays_idle", 32'(bus.halt), 32'h0);
    check("midreset_no_read", 32'(bus.dma_rd), 32'h0);

    // Clean restart from idx 0.
    start_xfer(8'h02, 1'b1);
    finish_xfer(8'h02, 1'b1, 514, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
